// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the valid/ready memory bus and its arbiter.
//   arb_state_e       : arbiter FSM states (IDLE, BUSY)
//   ERR_RDATA_DEFAULT : read data returned to a master whose transaction timed out
//   strb_is_read()    : a transaction with all byte strobes clear is a read
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Widest strobe vector the helper accepts; narrower strobes are zero-extended.
    localparam int STRB_MAX_W = 128;

    function automatic logic strb_is_read(input logic [STRB_MAX_W-1:0] wstrb);
        return (wstrb == '0);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter_if
// Bundle of NUM valid/ready memory ports sharing one read-data bus.
//   valid[NUM]         : request valid, one bit per port
//   addr/wdata/wstrb   : packed per-port request fields, port i at [i*W +: W]
//   ready[NUM]         : one-cycle completion pulse per port
//   rdata              : read data for the port whose ready is high
//   err[NUM]           : error flag, only meaningful together with ready
//
// Handshake: the requester raises valid with addr/wdata/wstrb and holds all of
// them stable until it sees ready. ready is a single-cycle completion pulse and
// rdata/err are valid in that same cycle. valid may not be dropped before ready.
// All-zero wstrb denotes a read.
//
// Modports: master issues requests, slave answers them.
// -----------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
    parameter int NUM    = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM-1:0]            valid;
    logic [NUM*ADDR_W-1:0]     addr;
    logic [NUM*DATA_W-1:0]     wdata;
    logic [NUM*(DATA_W/8)-1:0] wstrb;
    logic [NUM-1:0]            ready;
    logic [DATA_W-1:0]         rdata;
    logic [NUM-1:0]            err;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata, err
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata, err
    );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker.
//   req[NUM_MASTERS] : request vector
//   ptr              : highest-priority index for this pick
//   grant            : first requesting index at or after ptr, wrapping
//   any_req          : at least one request is present (grant valid)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_MASTERS = 3,
    parameter int PTR_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [PTR_W-1:0]       grant,
    output logic                   any_req
);

    int idx;

    // Walk the rotation from the far end back towards ptr so the last hit,
    // which is the one that sticks, is the closest requester at or after ptr.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (req[idx[PTR_W-1:0]]) begin
                grant   = PTR_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// N-master to one-slave arbiter for the valid/ready memory bus. Grants are
// round-robin, one transaction at a time, with an optional per-transaction
// timeout that completes the master with an error when the slave stalls.
//   clk, rst  : clock, synchronous active-high reset
//   m_bus     : NUM_MASTERS upstream ports (arbiter is the slave side)
//   s_bus     : single downstream port (arbiter is the master side)
//   busy      : a transaction is granted
//   grant_id  : granted master index while busy, 0 otherwise
//   dbg_state : FSM state
// Arbitration takes one IDLE cycle; completion is forwarded to the master in
// the same cycle the slave raises ready.
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                NUM_MASTERS    = 3,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst,
    mem_rr_arbiter_if.slave                m_bus,
    mem_rr_arbiter_if.master               s_bus,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output arb_state_e                     dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;

    logic [PTR_W-1:0]        pick_idx;
    logic                    any_req;
    logic                    tmo_hit;

    logic                    s_valid_c;
    logic [ADDR_W-1:0]       s_addr_c;
    logic [DATA_W-1:0]       s_wdata_c;
    logic [STRB_W-1:0]       s_wstrb_c;
    logic [NUM_MASTERS-1:0]  m_ready_c;
    logic [NUM_MASTERS-1:0]  m_err_c;
    logic [DATA_W-1:0]       m_rdata_c;

    // The downstream err line is not part of this bus's slave contract.
    logic                    unused_s_err;
    assign unused_s_err = s_bus.err[0];

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_rr_pick (
        .req     (m_bus.valid),
        .ptr     (rr_ptr_q),
        .grant   (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        s_valid_c = 1'b0;
        s_addr_c  = '0;
        s_wdata_c = '0;
        s_wstrb_c = '0;
        m_ready_c = '0;
        m_err_c   = '0;
        m_rdata_c = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d   = pick_idx;
                    tmo_cnt_d = '0;
                    state_d   = BUSY;
                end
            end

            BUSY: begin
                s_valid_c = 1'b1;
                s_addr_c  = m_bus.addr[grant_q*ADDR_W +: ADDR_W];
                s_wdata_c = m_bus.wdata[grant_q*DATA_W +: DATA_W];
                s_wstrb_c = m_bus.wstrb[grant_q*STRB_W +: STRB_W];

                // A slave ready in the last allowed cycle beats the timeout.
                tmo_hit = (TIMEOUT_CYCLES > 0) && !s_bus.ready[0] &&
                          (tmo_cnt_q == TMO_LAST);

                if (s_bus.ready[0] || tmo_hit) begin
                    m_ready_c[grant_q] = 1'b1;
                    m_err_c[grant_q]   = tmo_hit;
                    m_rdata_c          = s_bus.ready[0] ? s_bus.rdata : ERR_RDATA;
                    rr_ptr_d           = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d            = IDLE;
                end else if (TIMEOUT_CYCLES > 0) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // A transaction cut short by reset never reports completion.
        if (rst) begin
            m_ready_c = '0;
            m_err_c   = '0;
            m_rdata_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign m_bus.ready = m_ready_c;
    assign m_bus.err   = m_err_c;
    assign m_bus.rdata = m_rdata_c;

    assign s_bus.valid = s_valid_c;
    assign s_bus.addr  = s_addr_c;
    assign s_bus.wdata = s_wdata_c;
    assign s_bus.wstrb = s_wstrb_c;

    assign busy      = (state_q == BUSY);
    assign grant_id  = busy ? grant_q : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Directed and randomized bench for mem_rr_arbiter (3 masters, timeout of 4).
// Requests are issued in batches that all rise together and hold until served.
// The reference model derives the service order from the round-robin rule and
// the per-transaction timeline (one idle cycle, then min(latency+1, timeout)
// busy cycles) with plain arithmetic, and every cycle is checked against it.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;
  import mem_bus_pkg::*;

  localparam int NM  = 3;
  localparam int TMO = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] grant_id;
  arb_state_e dbg_state;

  mem_rr_arbiter_if #(.NUM(NM), .ADDR_W(32), .DATA_W(32)) up_bus ();
  mem_rr_arbiter_if #(.NUM(1),  .ADDR_W(32), .DATA_W(32)) dn_bus ();

  mem_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_bus     (up_bus),
    .s_bus     (dn_bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  logic [31:0] r_addr  [NM];
  logic [31:0] r_wdata [NM];
  logic [3:0]  r_wstrb [NM];
  logic [31:0] r_rdata [NM];
  int          r_lat   [NM];
  int          model_ptr;
  int          n_checks;
  int          n_fail;

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int lat);
    r_addr[m]  = a;
    r_wdata[m] = wd;
    r_wstrb[m] = ws;
    r_lat[m]   = lat;
    // The modelled slave returns data only for reads.
    r_rdata[m] = strb_is_read(128'(ws)) ? $urandom() : 32'h0;
    up_bus.addr[m*32 +: 32] = a;
    up_bus.wdata[m*32 +: 32] = wd;
    up_bus.wstrb[m*4 +: 4] = ws;
  endtask

  // One cycle in which nothing is granted; entered and left at posedge+1.
  task automatic check_idle();
    dn_bus.ready = 1'b0;
    dn_bus.rdata = $urandom();
    #2;
    chk("idle_busy",    64'(busy),          64'd0);
    chk("idle_state",   64'(dbg_state),     64'(IDLE));
    chk("idle_s_valid", 64'(dn_bus.valid),  64'd0);
    chk("idle_s_addr",  64'(dn_bus.addr),   64'd0);
    chk("idle_s_wdata", 64'(dn_bus.wdata),  64'd0);
    chk("idle_s_wstrb", 64'(dn_bus.wstrb),  64'd0);
    chk("idle_grant",   64'(grant_id),      64'd0);
    chk("idle_m_ready", 64'(up_bus.ready),  64'd0);
    chk("idle_m_err",   64'(up_bus.err),    64'd0);
    chk("idle_m_rdata", 64'(up_bus.rdata),  64'd0);
    @(posedge clk);
    #1;
  endtask

  // One busy cycle for master m; last marks the completing cycle.
  task automatic check_busy(input int m, input logic last, input logic to_err);
    logic [31:0] exp_rd;
    dn_bus.ready = last && !to_err;
    dn_bus.rdata = (last && !to_err) ? r_rdata[m] : $urandom();
    exp_rd = !last ? 32'h0 : (to_err ? 32'hDEAD_BEEF : r_rdata[m]);
    #2;
    chk("busy_busy",    64'(busy),         64'd1);
    chk("busy_state",   64'(dbg_state),    64'(BUSY));
    chk("busy_s_valid", 64'(dn_bus.valid), 64'd1);
    chk("busy_grant",   64'(grant_id),     64'(m));
    chk("busy_s_addr",  64'(dn_bus.addr),  64'(r_addr[m]));
    chk("busy_s_wdata", 64'(dn_bus.wdata), 64'(r_wdata[m]));
    chk("busy_s_wstrb", 64'(dn_bus.wstrb), 64'(r_wstrb[m]));
    chk("busy_m_ready", 64'(up_bus.ready), last ? (64'd1 << m) : 64'd0);
    chk("busy_m_err",   64'(up_bus.err),   (last && to_err) ? (64'd1 << m) : 64'd0);
    chk("busy_m_rdata", 64'(up_bus.rdata), 64'(exp_rd));
    @(posedge clk);
    #1;
    dn_bus.ready = 1'b0;
    dn_bus.rdata = 32'h0;
    if (last) up_bus.valid[m] = 1'b0;
  endtask

  task automatic serve(input int m);
    int   nb;
    logic to_err;
    to_err = (r_lat[m] >= TMO);
    nb     = to_err ? TMO : r_lat[m] + 1;
    for (int c = 1; c <= nb; c++) check_busy(m, c == nb, to_err);
  endtask

  // All masters in mask request together; order follows the rotation from the
  // model pointer, and the pointer lands just after the last one served.
  task automatic do_batch(input logic [2:0] mask);
    int order[$];
    int last;
    for (int k = 0; k < NM; k++) begin
      int m;
      m = (model_ptr + k) % NM;
      if (mask[m]) order.push_back(m);
    end
    up_bus.valid = mask;
    last = model_ptr - 1;
    foreach (order[j]) begin
      check_idle();
      serve(order[j]);
      last = order[j];
    end
    check_idle();
    model_ptr = (last + 1) % NM;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    model_ptr    = 0;
    rst          = 1'b1;
    up_bus.valid = '0;
    up_bus.addr  = '0;
    up_bus.wdata = '0;
    up_bus.wstrb = '0;
    dn_bus.ready = 1'b0;
    dn_bus.rdata = 32'h0;
    dn_bus.err   = 1'b0;
    for (int i = 0; i < NM; i++) set_req(i, 32'h0, 32'h0, 4'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check_idle();
    check_idle();

    // Fairness: all hold valid, zero-wait slave -> 0,1,2,0,1,2.
    for (int i = 0; i < NM; i++) set_req(i, 32'h40 * i, 32'h1000 + i, 4'h0, 0);
    do_batch(3'b111);
    for (int i = 0; i < NM; i++) set_req(i, 32'h80 * i, 32'h2000 + i, 4'hF, 0);
    do_batch(3'b111);

    // Single read from master 1, ready two cycles after s_valid.
    set_req(1, 32'h100, 32'h0, 4'h0, 2);
    r_rdata[1] = 32'h1234_5678;
    do_batch(3'b010);

    // Pointer wrap: pointer at 2, only master 0 requests.
    set_req(0, 32'h300, 32'h5555_AAAA, 4'h0, 1);
    do_batch(3'b001);
    // Pointer is now 1: a full batch must start at master 1.
    for (int i = 0; i < NM; i++) set_req(i, 32'h500 + i, $urandom(), 4'h0, 1);
    do_batch(3'b111);

    // Write routing on master 2.
    set_req(2, 32'h2000, 32'hCAFE_F00D, 4'b0011, 1);
    do_batch(3'b100);

    // Timeout: slave never ready, then ready exactly on the last allowed cycle.
    set_req(0, 32'h600, 32'h0, 4'h0, 100);
    do_batch(3'b001);
    set_req(0, 32'h604, 32'h0, 4'h0, TMO - 1);
    do_batch(3'b001);

    // Reset while busy with master 1; it stays pending and is re-arbitrated.
    set_req(1, 32'h700, 32'h0, 4'h0, 1);
    up_bus.valid = 3'b010;
    check_idle();
    check_busy(1, 1'b0, 1'b0);
    check_busy(1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("rst_m_ready", 64'(up_bus.ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    check_idle();
    serve(1);
    check_idle();
    model_ptr = 2;

    // Reset while idle with pointer at 2 clears the pointer to 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < NM; i++) set_req(i, 32'h800 + i, $urandom(), 4'h0, 0);
    do_batch(3'b111);

    // Randomized batches, latencies spanning both sides of the timeout.
    for (int b = 0; b < 40; b++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < NM; i++) begin
        set_req(i, $urandom(), $urandom(),
                ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                $urandom_range(0, 5));
      end
      do_batch(mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
